// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// Module : mips_pkg
// Brief  : Shared MIPS datapath definitions: word width, divider state
//          encoding and the divide-by-zero quotient constant.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int WORD_W = 32;

  // Divider control states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient reported when the divisor is zero (all ones, as a MIPS core would see)
  localparam logic [WORD_W-1:0] DIV_ZERO_QUOT = {WORD_W{1'b1}};

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mips_divu_step.sv
// ---------------------------------------------------------------------------
// Module : mips_divu_step
// Brief  : One combinational restoring-division step. Shifts {R,Q} left by
//          one, trial-subtracts the divisor and produces the new quotient bit.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mips_divu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // R < divisor always holds, so the shifted remainder is below 2*divisor and
  // a WIDTH+1-bit difference is enough: bit WIDTH is the borrow.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Restoring step: keep the difference only when it did not borrow
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule : mips_divu_step

`default_nettype wire

// File: rtl/mips_divu.sv
// ---------------------------------------------------------------------------
// Module : mips_divu
// Brief  : Multi-cycle unsigned restoring divider (divu). One quotient bit per
//          clock under a start/busy/done handshake; quotient feeds LO and
//          remainder feeds HI.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mips_divu
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] work_r_q, work_r_d;   // partial remainder
  logic [WIDTH-1:0] work_q_q, work_q_d;   // dividend shifting into quotient
  logic [WIDTH-1:0] dsor_q, dsor_d;       // divisor captured at accept
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  mips_divu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (work_r_q),
    .quo_i     (work_q_q),
    .divisor_i (dsor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state logic: accept in IDLE/DONE, iterate in RUN, publish on the last step
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    work_r_d = work_r_q;
    work_q_d = work_q_q;
    dsor_d   = dsor_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (start) begin
          if (divisor == '0) begin
            // No iteration needed: results are fixed by the operands
            quot_d  = DIV_ZERO_QUOT[WIDTH-1:0];
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DIV_DONE;
          end else begin
            work_q_d = dividend;
            work_r_d = '0;
            dsor_d   = divisor;
            count_d  = '0;
            dbz_d    = 1'b0;
            state_d  = DIV_RUN;
          end
        end
      end

      DIV_RUN: begin
        work_r_d = step_rem;
        work_q_d = step_quo;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          quot_d  = step_quo;
          rem_d   = step_rem;
          done_d  = 1'b1;
          state_d = DIV_DONE;
        end
      end

      default: state_d = DIV_IDLE;
    endcase

    busy_d = (state_d == DIV_RUN);
  end

  // State, working and output registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      count_q  <= '0;
      work_r_q <= '0;
      work_q_q <= '0;
      dsor_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_r_q <= work_r_d;
      work_q_q <= work_q_d;
      dsor_q   <= dsor_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : mips_divu

`default_nettype wire

// File: tb/tb_mips_divu.sv
// ---------------------------------------------------------------------------
// Module : tb_mips_divu
// Brief  : Directed self-checking bench for mips_divu.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_divu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  mips_divu #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from a negedge and wait (bounded) for done. lat counts
  // rising edges after the accepting edge until done is seen; a timeout
  // returns lat = 40. Optionally injects a second start pulse at cycle inj_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input logic [31:0] ia,
                        input logic [31:0] ib, output int lat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == inj_at) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (quotient !== 32'h0)   begin miscompares++; $display("FAIL reset_quot got=%h exp=0", quotient); end
    vectors++; if (remainder !== 32'h0)  begin miscompares++; $display("FAIL reset_rem got=%h exp=0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 100 / 7 = 14 r 2, done exactly 32 edges after acceptance, then held
  task automatic test_basic();
    int lat;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", busy); end
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    vectors++; if (lat !== 32)             begin miscompares++; $display("FAIL basic_lat got=%0d exp=32", lat); end
    vectors++; if (quotient !== 32'd14)    begin miscompares++; $display("FAIL basic_quot got=%0d exp=14", quotient); end
    vectors++; if (remainder !== 32'd2)    begin miscompares++; $display("FAIL basic_rem got=%0d exp=2", remainder); end
    vectors++; if (div_by_zero !== 1'b0)   begin miscompares++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0)          begin miscompares++; $display("FAIL basic_pulse got=%b exp=0", done); end
    vectors++; if (quotient !== 32'd14)    begin miscompares++; $display("FAIL basic_hold got=%0d exp=14", quotient); end
  endtask

  // 0xFFFFFFFF / 1, then 3 / 10 issued in the DONE cycle
  task automatic test_back_to_back();
    int lat;
    run_op(32'hFFFF_FFFF, 32'd1, -1, '0, '0, lat);
    vectors++; if (lat !== 32)               begin miscompares++; $display("FAIL b2b1_lat got=%0d exp=32", lat); end
    vectors++; if (quotient !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL b2b1_quot got=%h exp=ffffffff", quotient); end
    vectors++; if (remainder !== 32'h0)      begin miscompares++; $display("FAIL b2b1_rem got=%h exp=0", remainder); end
    run_op(32'd3, 32'd10, -1, '0, '0, lat);
    vectors++; if (lat !== 32)               begin miscompares++; $display("FAIL b2b2_lat got=%0d exp=32", lat); end
    vectors++; if (quotient !== 32'd0)       begin miscompares++; $display("FAIL b2b2_quot got=%0d exp=0", quotient); end
    vectors++; if (remainder !== 32'd3)      begin miscompares++; $display("FAIL b2b2_rem got=%0d exp=3", remainder); end
    @(negedge clk);
  endtask

  // 0x12345678 / 0: finishes on the accepting edge, busy never rises
  task automatic test_div_zero();
    int lat;
    run_op(32'h1234_5678, 32'd0, -1, '0, '0, lat);
    vectors++; if (lat !== 0)                  begin miscompares++; $display("FAIL dz_lat got=%0d exp=0", lat); end
    vectors++; if (busy !== 1'b0)              begin miscompares++; $display("FAIL dz_busy got=%b exp=0", busy); end
    vectors++; if (quotient !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_quot got=%h exp=ffffffff", quotient); end
    vectors++; if (remainder !== 32'h1234_5678) begin miscompares++; $display("FAIL dz_rem got=%h exp=12345678", remainder); end
    vectors++; if (div_by_zero !== 1'b1)       begin miscompares++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    @(negedge clk);
    vectors++; if (div_by_zero !== 1'b1)       begin miscompares++; $display("FAIL dz_hold got=%b exp=1", div_by_zero); end
    vectors++; if (busy !== 1'b0)              begin miscompares++; $display("FAIL dz_busy2 got=%b exp=0", busy); end
  endtask

  // 1000 / 3 with a stray 50 / 5 start at cycle 10; outputs hold during RUN
  task automatic test_ignore_start();
    int lat;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
      if (lat == 10) begin
        vectors++; if (quotient !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ign_hold_quot got=%h exp=ffffffff", quotient); end
        vectors++; if (div_by_zero !== 1'b0)       begin miscompares++; $display("FAIL ign_dbz_clear got=%b exp=0", div_by_zero); end
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    vectors++; if (lat !== 32)            begin miscompares++; $display("FAIL ign_lat got=%0d exp=32", lat); end
    vectors++; if (quotient !== 32'd333)  begin miscompares++; $display("FAIL ign_quot got=%0d exp=333", quotient); end
    vectors++; if (remainder !== 32'd1)   begin miscompares++; $display("FAIL ign_rem got=%0d exp=1", remainder); end
    @(negedge clk);
  endtask

  // Asynchronous reset at cycle 15 of 0x80000000 / 0x10, then 9 / 4
  task automatic test_reset_midrun();
    int lat;
    start = 1'b1; dividend = 32'h8000_0000; divisor = 32'h10;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
    vectors++; if (quotient !== 32'h0)   begin miscompares++; $display("FAIL rst_quot got=%h exp=0", quotient); end
    vectors++; if (remainder !== 32'h0)  begin miscompares++; $display("FAIL rst_rem got=%h exp=0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL rst_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd9, 32'd4, -1, '0, '0, lat);
    vectors++; if (lat !== 32)          begin miscompares++; $display("FAIL post_rst_lat got=%0d exp=32", lat); end
    vectors++; if (quotient !== 32'd2)  begin miscompares++; $display("FAIL post_rst_quot got=%0d exp=2", quotient); end
    vectors++; if (remainder !== 32'd1) begin miscompares++; $display("FAIL post_rst_rem got=%0d exp=1", remainder); end
    @(negedge clk);
  endtask

  // Boundary operands plus back-to-back random pairs biased toward zero divisors
  task automatic test_random();
    int          lat;
    int          exp_lat;
    logic [31:0] a, b, q_e, r_e;
    logic        z_e;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        1: begin a = 32'd0;         b = 32'd5;         end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = 32'hFFFF_FFFE; b = 32'h8000_0000; end
        default: begin
          a = $urandom;
          case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 16);
            2:       b = a;
            default: b = $urandom >> $urandom_range(0, 31);
          endcase
        end
      endcase
      if (b == 32'd0) begin
        q_e = 32'hFFFF_FFFF; r_e = a; z_e = 1'b1; exp_lat = 0;
      end else begin
        q_e = a / b;         r_e = a % b; z_e = 1'b0; exp_lat = 32;
      end
      run_op(a, b, -1, '0, '0, lat);
      vectors++; if (lat !== exp_lat)      begin miscompares++; $display("FAIL rnd_lat a=%h b=%h got=%0d exp=%0d", a, b, lat, exp_lat); end
      vectors++; if (quotient !== q_e)     begin miscompares++; $display("FAIL rnd_quot a=%h b=%h got=%h exp=%h", a, b, quotient, q_e); end
      vectors++; if (remainder !== r_e)    begin miscompares++; $display("FAIL rnd_rem a=%h b=%h got=%h exp=%h", a, b, remainder, r_e); end
      vectors++; if (div_by_zero !== z_e)  begin miscompares++; $display("FAIL rnd_dbz a=%h b=%h got=%b exp=%b", a, b, div_by_zero, z_e); end
      if (lat >= 40) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mips_divu

`default_nettype wire
